// File: rtl/mandel_iter_core_if.sv
// Pixel request/result bundle for mandel_iter_core.
// The master issues a pixel and reads back the result; the slave is the core.
interface mandel_iter_core_if #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int MAX_ITER_WIDTH  = 16
);
    localparam int DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS;

    logic                         start_i;
    logic [MAX_ITER_WIDTH-1:0]    max_iter_i;
    logic signed [DATA_WIDTH-1:0] x0_i;
    logic signed [DATA_WIDTH-1:0] y0_i;
    logic [MAX_ITER_WIDTH-1:0]    iter_o;
    logic                         done_o;
    logic                         busy_o;

    modport master (output start_i, max_iter_i, x0_i, y0_i,
                    input  iter_o, done_o, busy_o);
    modport slave  (input  start_i, max_iter_i, x0_i, y0_i,
                    output iter_o, done_o, busy_o);
endinterface

// File: rtl/mandel_iter_core.sv
// Escape-time Mandelbrot iterator: one z <- z^2 + c step per clock in signed
// fixed point, reporting the iteration count at escape or at the limit.
module mandel_iter_core #(
    parameter int INTEGER_BITS    = 8,
    parameter int FRACTIONAL_BITS = 24,
    parameter int MAX_ITER_WIDTH  = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    mandel_iter_core_if.slave bus
);
    localparam int DATA_WIDTH = INTEGER_BITS + FRACTIONAL_BITS;
    localparam int PW         = 2 * DATA_WIDTH;
    localparam logic signed [PW:0] FOUR = (PW+1)'(4) << (2 * FRACTIONAL_BITS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                       state, state_n;
    logic signed [DATA_WIDTH-1:0] zx, zy, x0, y0;
    logic [MAX_ITER_WIDTH-1:0]    max_iter, iter, iter_q;
    logic                         done_q;

    logic signed [PW-1:0]         zx_sq, zy_sq, zxy, re_full;
    logic signed [PW:0]           mag;
    logic signed [DATA_WIDTH-1:0] re_sh, im_sh;
    logic                         escaped, load, finish, step;

    assign zx_sq   = PW'(zx) * PW'(zx);
    assign zy_sq   = PW'(zy) * PW'(zy);
    assign zxy     = PW'(zx) * PW'(zy);
    assign mag     = (PW+1)'(zx_sq) + (PW+1)'(zy_sq);
    assign escaped = mag > FOUR;
    assign re_full = zx_sq - zy_sq;

    // Slicing one bit lower folds the factor of two into the shift.
    assign re_sh = re_full[FRACTIONAL_BITS +: DATA_WIDTH];
    assign im_sh = zxy[FRACTIONAL_BITS-1 +: DATA_WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        finish  = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    load    = 1'b1;
                    state_n = CALC;
                end
            end
            CALC: begin
                if (escaped || iter == max_iter) begin
                    finish  = 1'b1;
                    state_n = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            zx       <= '0;
            zy       <= '0;
            x0       <= '0;
            y0       <= '0;
            max_iter <= '0;
            iter     <= '0;
            iter_q   <= '0;
            done_q   <= 1'b0;
        end else if (load) begin
            x0       <= bus.x0_i;
            y0       <= bus.y0_i;
            max_iter <= bus.max_iter_i;
            zx       <= '0;
            zy       <= '0;
            iter     <= '0;
            done_q   <= 1'b0;
        end else if (finish) begin
            iter_q <= iter;
            done_q <= 1'b1;
        end else if (step) begin
            zx   <= re_sh + x0;
            zy   <= im_sh + y0;
            iter <= iter + 1'b1;
        end
    end

    assign bus.iter_o = iter_q;
    assign bus.done_o = done_q;
    assign bus.busy_o = (state == CALC);
endmodule
